mot_comm_seq: RTL and testbench

Parametrised commutation sequencer for the motor drive path. Advances through a programmable table of N_STEP gate patterns on each falling edge of an external step strobe, in either direction, with break-before-make dead time, PWM chopping of high-side gates, enable/brake control and a stall watchdog. Sits between the commutation-timing source and the gate-driver pins, fully synchronous to MOT_CLK.

---
 rtl/mot_comm_seq.sv | 176 +++++++++++++++++
 tb/tb_mot_comm_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mot_comm_seq.sv
// Commutation sequencer: steps through a gate-pattern table on step-strobe falls,
// with break-before-make dead time, PWM chopping of high-side gates, brake and stall fault.
module mot_comm_seq #(
  parameter int unsigned      N_CH      = 6,
  parameter int unsigned      N_STEP    = 6,
  parameter int unsigned      DEAD_CYC  = 8,
  parameter int unsigned      STALL_CYC = 32'd3_200_000,
  parameter logic [N_CH-1:0]  HS_MASK   = 6'b101010,
  parameter logic [N_CH-1:0]  BRAKE_PAT = 6'b010101,
  localparam int unsigned     IW        = $clog2(N_STEP)
) (
  input  logic            MOT_CLK,
  input  logic            MOT_RST,
  input  logic            step_in,
  input  logic            pwm_in,
  input  logic            en,
  input  logic            dir,
  input  logic            brake,
  input  logic            tbl_we,
  input  logic [IW-1:0]   tbl_addr,
  input  logic [N_CH-1:0] tbl_wdata,
  output logic [N_CH-1:0] mot_pwm_out,
  output logic [IW-1:0]   step_idx,
  output logic [2:0]      state_o,
  output logic            stall_flt
);

  localparam int unsigned DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam int unsigned SW = 32;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DEAD  = 3'd1;
  localparam logic [2:0] S_DRIVE = 3'd2;
  localparam logic [2:0] S_BRAKE = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic            step_s1_q, step_s2_q, step_s3_q;
  logic            pwm_s1_q, pwm_s2_q;
  logic [2:0]      st_q, st_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   dead_cnt_q, dead_cnt_d;
  logic [SW-1:0]   stall_cnt_q, stall_cnt_d;
  logic [N_CH-1:0] out_q, out_d;
  logic            flt_q;
  logic [N_CH-1:0] tbl_q [N_STEP];

  logic            step_edge_c;
  logic            run_c;
  logic            stall_hit_c;
  logic            dead_done_c;
  logic [IW-1:0]   idx_adv_c;
  logic [2:0]      dead_tgt_c;

  // Power-on commutation table for the standard 6-channel, 6-step drive.
  function automatic logic [N_CH-1:0] tbl_default(input int unsigned i);
    logic [5:0] p;
    case (i)
      0:       p = 6'b100110;
      1:       p = 6'b100101;
      2:       p = 6'b101001;
      3:       p = 6'b011001;
      4:       p = 6'b011010;
      5:       p = 6'b010110;
      default: p = 6'b000000;
    endcase
    if (N_CH == 6 && N_STEP == 6) return N_CH'(p);
    return '0;
  endfunction

  // Two-flop synchronisers plus a delay stage for falling-edge detection.
  always_ff @(posedge MOT_CLK or posedge MOT_RST) begin
    if (MOT_RST) begin
      step_s1_q <= 1'b1;
      step_s2_q <= 1'b1;
      step_s3_q <= 1'b1;
      pwm_s1_q  <= 1'b0;
      pwm_s2_q  <= 1'b0;
    end else begin
      step_s1_q <= step_in;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
      pwm_s1_q  <= pwm_in;
      pwm_s2_q  <= pwm_s1_q;
    end
  end

  always_ff @(posedge MOT_CLK or posedge MOT_RST) begin
    if (MOT_RST) begin
      for (int unsigned i = 0; i < N_STEP; i++) tbl_q[i] <= tbl_default(i);
    end else if (tbl_we && (32'(tbl_addr) < N_STEP)) begin
      tbl_q[tbl_addr] <= tbl_wdata;
    end
  end

  always_ff @(posedge MOT_CLK or posedge MOT_RST) begin
    if (MOT_RST) begin
      st_q        <= S_IDLE;
      idx_q       <= '0;
      dead_cnt_q  <= '0;
      stall_cnt_q <= '0;
      out_q       <= '0;
      flt_q       <= 1'b0;
    end else begin
      st_q        <= st_d;
      idx_q       <= idx_d;
      dead_cnt_q  <= dead_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      out_q       <= out_d;
      flt_q       <= (st_d == S_FAULT);
    end
  end

  always_comb begin
    st_d        = st_q;
    idx_d       = idx_q;
    dead_cnt_d  = '0;
    stall_cnt_d = '0;
    out_d       = '0;

    step_edge_c = step_s3_q & ~step_s2_q;
    run_c       = (st_q == S_DEAD) || (st_q == S_DRIVE);
    stall_hit_c = (STALL_CYC != 0) && run_c && (stall_cnt_q == STALL_CYC - 32'd1);
    dead_done_c = (dead_cnt_q == DW'(DEAD_CYC - 1));

    if (dir) idx_adv_c = (idx_q == IW'(N_STEP - 1)) ? '0 : idx_q + IW'(1);
    else     idx_adv_c = (idx_q == '0) ? IW'(N_STEP - 1) : idx_q - IW'(1);

    // With no dead time the all-off phase collapses straight into its successor.
    if (DEAD_CYC == 0) dead_tgt_c = brake ? S_BRAKE : S_DRIVE;
    else               dead_tgt_c = S_DEAD;

    if (!en) begin
      st_d = S_IDLE;
    end else if (stall_hit_c) begin
      st_d = S_FAULT;
    end else begin
      case (st_q)
        S_IDLE:  st_d = dead_tgt_c;
        S_DEAD: begin
          if (step_edge_c)      idx_d = idx_adv_c;
          else if (dead_done_c) st_d  = brake ? S_BRAKE : S_DRIVE;
        end
        S_DRIVE: begin
          if (brake) begin
            st_d = dead_tgt_c;
          end else if (step_edge_c) begin
            idx_d = idx_adv_c;
            st_d  = dead_tgt_c;
          end
        end
        S_BRAKE: if (!brake) st_d = dead_tgt_c;
        S_FAULT: st_d = S_FAULT;
        default: st_d = S_IDLE;
      endcase
    end

    // Dead counter restarts on every entry to DEAD and on each step inside it.
    if ((st_q == S_DEAD) && (st_d == S_DEAD) && !step_edge_c)
      dead_cnt_d = dead_cnt_q + DW'(1);

    if ((STALL_CYC != 0) && run_c && ((st_d == S_DEAD) || (st_d == S_DRIVE)) && !step_edge_c)
      stall_cnt_d = stall_cnt_q + 32'd1;

    case (st_d)
      S_DRIVE: out_d = tbl_q[idx_d] & ~(HS_MASK & {N_CH{~pwm_s2_q}});
      S_BRAKE: out_d = BRAKE_PAT;
      default: out_d = '0;
    endcase
  end

  assign mot_pwm_out = out_q;
  assign step_idx    = idx_q;
  assign state_o     = st_q;
  assign stall_flt   = flt_q;

endmodule

// File: tb/tb_mot_comm_seq.sv
// Bench for mot_comm_seq: directed test-plan steps plus a random phase, all checked
// cycle by cycle against a timestamp-based reference model.
module tb_mot_comm_seq;

  localparam int unsigned STALL = 100;
  localparam int          DEADC = 8;
  localparam logic [5:0]  HS    = 6'b101010;
  localparam logic [5:0]  BRK   = 6'b010101;

  localparam int M_IDLE  = 0;
  localparam int M_DEAD  = 1;
  localparam int M_DRIVE = 2;
  localparam int M_BRAKE = 3;
  localparam int M_FAULT = 4;

  logic       MOT_CLK = 1'b0;
  logic       MOT_RST;
  logic       step_in, pwm_in, en, dir, brake, tbl_we;
  logic [2:0] tbl_addr;
  logic [5:0] tbl_wdata;
  logic [5:0] mot_pwm_out;
  logic [2:0] step_idx;
  logic [2:0] state_o;
  logic       stall_flt;

  int total = 0;
  int bad   = 0;

  // Reference model: edge count, input histories, mode, and event timestamps.
  int         n;
  logic       sv_q[$];
  logic       pv_q[$];
  int         m_mode, m_idx, t_dead, t_ref;
  logic [5:0] m_tbl [6];
  logic [5:0] m_out;

  mot_comm_seq #(.STALL_CYC(STALL)) dut (
    .MOT_CLK(MOT_CLK), .MOT_RST(MOT_RST), .step_in(step_in), .pwm_in(pwm_in),
    .en(en), .dir(dir), .brake(brake), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .mot_pwm_out(mot_pwm_out), .step_idx(step_idx),
    .state_o(state_o), .stall_flt(stall_flt)
  );

  always #5 MOT_CLK = ~MOT_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic step_at(input int k);
    return (k < 0) ? 1'b1 : sv_q[k];
  endfunction

  function automatic logic pwm_at(input int k);
    return (k < 0) ? 1'b0 : pv_q[k];
  endfunction

  task automatic model_reset();
    n = 0;
    sv_q.delete();
    pv_q.delete();
    m_mode = M_IDLE;
    m_idx  = 0;
    t_dead = 0;
    t_ref  = 0;
    m_out  = '0;
    m_tbl  = '{6'b100110, 6'b100101, 6'b101001, 6'b011001, 6'b011010, 6'b010110};
  endtask

  function automatic logic in_run(input int md);
    return (md == M_DEAD) || (md == M_DRIVE);
  endfunction

  task automatic model_edge();
    logic       ev;
    int         pre, nidx;
    logic [5:0] pat;
    sv_q.push_back(step_in);
    pv_q.push_back(pwm_in);
    ev   = step_at(n - 3) && !step_at(n - 2);
    nidx = dir ? (m_idx + 1) % 6 : (m_idx + 5) % 6;
    pre  = m_mode;
    if (!en) m_mode = M_IDLE;
    else if (in_run(pre) && (n - t_ref == int'(STALL))) m_mode = M_FAULT;
    else begin
      case (pre)
        M_IDLE: begin m_mode = M_DEAD; t_dead = n; end
        M_DEAD: begin
          if (ev) begin m_idx = nidx; t_dead = n; end
          else if (n - t_dead == DEADC) m_mode = brake ? M_BRAKE : M_DRIVE;
        end
        M_DRIVE: begin
          if (brake) begin m_mode = M_DEAD; t_dead = n; end
          else if (ev) begin m_idx = nidx; m_mode = M_DEAD; t_dead = n; end
        end
        M_BRAKE: if (!brake) begin m_mode = M_DEAD; t_dead = n; end
        default: ;
      endcase
    end
    // The stall window opens on entering DEAD/DRIVE and reopens on every step edge.
    if (in_run(m_mode) && (!in_run(pre) || ev)) t_ref = n;
    pat = m_tbl[m_idx];
    if (!pwm_at(n - 2)) pat = pat & ~HS;
    if (m_mode == M_DRIVE)      m_out = pat;
    else if (m_mode == M_BRAKE) m_out = BRK;
    else                        m_out = '0;
    if (tbl_we && tbl_addr < 3'd6) m_tbl[tbl_addr] = tbl_wdata;
    n++;
  endtask

  task automatic tick();
    @(posedge MOT_CLK);
    model_edge();
    @(negedge MOT_CLK);
    check("out",   32'(mot_pwm_out), 32'(m_out));
    check("idx",   32'(step_idx),    32'(m_idx));
    check("state", 32'(state_o),     32'(m_mode));
    check("flt",   32'(stall_flt),   32'(m_mode == M_FAULT));
  endtask

  task automatic step_fall(input int lo, input int hi);
    step_in = 1'b0;
    repeat (lo) tick();
    step_in = 1'b1;
    repeat (hi) tick();
  endtask

  initial begin
    MOT_RST = 1'b1; step_in = 1'b1; pwm_in = 1'b1; en = 1'b0; dir = 1'b1;
    brake = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
    repeat (3) @(negedge MOT_CLK);
    check("rst_out",   32'(mot_pwm_out), 32'd0);
    check("rst_idx",   32'(step_idx),    32'd0);
    check("rst_state", 32'(state_o),     32'd0);
    check("rst_flt",   32'(stall_flt),   32'd0);
    MOT_RST = 1'b0;
    model_reset();

    // Enable: 8 off cycles, then the idx-0 pattern.
    en = 1'b1;
    repeat (8) tick();
    check("first_off", 32'(mot_pwm_out), 32'd0);
    tick();
    check("first_pat", 32'(mot_pwm_out), 32'(6'b100110));
    repeat (3) tick();

    for (int i = 0; i < 6; i++) step_fall(3, 12);
    check("fwd_wrap_idx", 32'(step_idx),    32'd0);
    check("fwd_wrap_out", 32'(mot_pwm_out), 32'(6'b100110));

    dir = 1'b0;
    step_fall(3, 12);
    check("rev1_idx", 32'(step_idx),    32'd5);
    check("rev1_out", 32'(mot_pwm_out), 32'(6'b010110));
    step_fall(3, 12);
    check("rev2_idx", 32'(step_idx),    32'd4);
    check("rev2_out", 32'(mot_pwm_out), 32'(6'b011010));
    dir = 1'b1;
    step_fall(3, 12);
    step_fall(3, 12);

    // PWM chop latency at idx 0.
    pwm_in = 1'b0;
    tick(); tick();
    check("pwm_lat2", 32'(mot_pwm_out), 32'(6'b100110));
    tick();
    check("pwm_lat3", 32'(mot_pwm_out), 32'(6'b000100));
    pwm_in = 1'b1;
    repeat (3) tick();
    check("pwm_rel", 32'(mot_pwm_out), 32'(6'b100110));
    for (int i = 0; i < 6; i++) begin
      pwm_in = ~pwm_in;
      repeat (4) tick();
    end

    // Two steps 4 cycles apart inside the dead window.
    step_in = 1'b0; repeat (2) tick();
    step_in = 1'b1; repeat (2) tick();
    step_in = 1'b0; repeat (2) tick();
    step_in = 1'b1; repeat (14) tick();
    check("dbl_idx", 32'(step_idx),    32'd2);
    check("dbl_out", 32'(mot_pwm_out), 32'(6'b101001));

    // Brake from DRIVE, table write while braked.
    brake = 1'b1;
    repeat (8) tick();
    check("brk_off", 32'(mot_pwm_out), 32'd0);
    tick();
    check("brk_pat",   32'(mot_pwm_out), 32'(6'b010101));
    check("brk_state", 32'(state_o),     32'd3);
    tbl_we = 1'b1; tbl_addr = 3'd2; tbl_wdata = 6'b111000;
    tick();
    tbl_we = 1'b0;
    repeat (3) tick();
    brake = 1'b0;
    repeat (4) tick();
    dir = 1'b0;
    step_fall(3, 12);
    dir = 1'b1;
    step_fall(3, 12);
    check("wr_idx", 32'(step_idx),    32'd2);
    check("wr_out", 32'(mot_pwm_out), 32'(6'b111000));

    // Write to the active index while driving.
    tbl_we = 1'b1; tbl_addr = 3'd2; tbl_wdata = 6'b001100;
    tick();
    tbl_we = 1'b0;
    check("live_wr0", 32'(mot_pwm_out), 32'(6'b111000));
    tick();
    check("live_wr1", 32'(mot_pwm_out), 32'(6'b001100));

    // Step edge coinciding with en=0.
    step_in = 1'b0;
    tick(); tick();
    en = 1'b0;
    tick();
    check("en_lo_state", 32'(state_o),  32'd0);
    check("en_lo_idx",   32'(step_idx), 32'd2);
    step_in = 1'b1;
    repeat (3) tick();

    // Stall watchdog.
    en = 1'b1;
    repeat (100) tick();
    check("pre_stall", 32'(state_o), 32'd2);
    tick();
    check("stall_state", 32'(state_o),     32'd4);
    check("stall_flt",   32'(stall_flt),   32'd1);
    check("stall_out",   32'(mot_pwm_out), 32'd0);
    repeat (5) tick();
    en = 1'b0;
    tick();
    check("flt_clr_state", 32'(state_o),   32'd0);
    check("flt_clr_flt",   32'(stall_flt), 32'd0);

    // Random phase.
    en = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 15) == 0)  step_in = ~step_in;
      if ($urandom_range(0, 3) == 0)   pwm_in  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)   dir     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 39) == 0)  brake   = ~brake;
      if ($urandom_range(0, 99) == 0)  en      = ~en;
      tbl_we    = ($urandom_range(0, 24) == 0);
      tbl_addr  = 3'($urandom_range(0, 7));
      tbl_wdata = 6'($urandom);
      tick();
    end
    tbl_we = 1'b0; brake = 1'b0; step_in = 1'b1; pwm_in = 1'b1; dir = 1'b1;

    // Asynchronous reset mid-drive.
    en = 1'b0;
    repeat (4) tick();
    en = 1'b1;
    repeat (12) tick();
    #2 MOT_RST = 1'b1;
    #1;
    check("arst_out",   32'(mot_pwm_out), 32'd0);
    check("arst_idx",   32'(step_idx),    32'd0);
    check("arst_state", 32'(state_o),     32'd0);
    check("arst_flt",   32'(stall_flt),   32'd0);
    @(negedge MOT_CLK);
    @(negedge MOT_CLK);
    MOT_RST = 1'b0;
    model_reset();
    repeat (12) tick();
    check("post_rst_pat", 32'(mot_pwm_out), 32'(6'b100110));
    step_fall(3, 12);
    step_fall(3, 12);
    check("post_rst_tbl", 32'(mot_pwm_out), 32'(6'b101001));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
